// File: rtl/seven_segment_pkg.sv
// Shared seven-segment constants: segment bit positions, digit patterns
// (active-high, bit0=a .. bit6=g) and the BCD-to-pattern lookup.
package seven_segment_pkg;

    typedef logic [6:0] seg_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam seg_t SEG_ALL   = seg_t'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D)
                                      | (1 << SEG_E) | (1 << SEG_F) | (1 << SEG_G));
    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7C;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = SEG_ALL;
    localparam seg_t SEG_9     = 7'h67;

    // Non-BCD codes (10..15) are shown dark rather than as hex glyphs.
    function automatic seg_t bcd_to_seg(input logic [3:0] nibble);
        seg_t pattern;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_segment_mux_if.sv
// Bundle between the scan logic and the nibble decoder: selected nibble and
// blank request in, active-high segment pattern out.
interface seven_segment_mux_if;
    import seven_segment_pkg::*;

    logic [3:0] nibble;
    logic       blank;
    seg_t       pattern;

    modport master (output nibble, output blank, input pattern);
    modport slave  (input nibble, input blank, output pattern);

endinterface

// File: rtl/seven_segment_mux_decoder.sv
// Combinational nibble decoder; a blank request overrides the BCD value.
module seg7_decoder
    import seven_segment_pkg::*;
(
    seven_segment_mux_if.slave bus
);

    assign bus.pattern = bus.blank ? SEG_BLANK : bcd_to_seg(bus.nibble);

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver: snapshots BCD digits, scans them one
// at a time with optional leading-zero blanking and output polarity inversion.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    invert,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    fs_q, fs_d;
    logic                    tick;

    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS:1]     zero_above;
    logic [NUM_DIGITS-1:0]   blank_vec;

    // zero_above[k]: snapshot nibbles k..NUM_DIGITS-1 are all zero.
    assign zero_above[NUM_DIGITS] = 1'b1;
    assign blank_vec[0]           = 1'b0;
    assign nib[0]                 = snap_q[3:0];

    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib[gi]        = snap_q[4*gi +: 4];
        assign zero_above[gi] = (nib[gi] == 4'd0) && zero_above[gi+1];
        assign blank_vec[gi]  = (BLANK_LEADING != 0) && zero_above[gi];
    end

    seven_segment_mux_if dec_bus ();

    assign dec_bus.nibble = nib[idx_q];
    assign dec_bus.blank  = blank_vec[idx_q];

    seg7_decoder u_decoder (
        .bus (dec_bus.slave)
    );

    always_comb begin
        snap_d  = load ? digits_in : snap_q;
        tick    = (presc_q == PRE_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        sel_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
        seg_d = dec_bus.pattern ^ (invert ? SEG_ALL : SEG_BLANK);
        // Entering digit 0 from anything else: a wrap or the first cycle out of reset.
        fs_d  = (idx_q == '0) && !sel_q[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            sel_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            fs_q    <= fs_d;
        end
    end

    assign segments    = seg_q;
    assign digit_sel   = sel_q;
    assign frame_start = fs_q;

endmodule
